// File: rtl/fpu_issue_seq.sv
// Issue/writeback sequencer in front of the 24-bit FPU: buffers tagged ops in a FIFO,
// issues them without class hazards and emits one tagged writeback per captured result.
module fpu_issue_seq #(
  parameter int WIDTH    = 24,
  parameter int TAG_W    = 5,
  parameter int DEPTH    = 4,
  parameter int ADD_LAT  = 2,
  parameter int MUL_LAT  = 2,
  parameter int MISC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_opcode,
  input  logic [TAG_W-1:0] in_tag,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  output logic [3:0]       fpu_opcode,
  input  logic [WIDTH-1:0] fpu_result,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [WIDTH-1:0] wb_result,
  output logic             busy
);

  localparam int AM_LAT  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int MAX_LAT = (AM_LAT > MISC_LAT) ? AM_LAT : MISC_LAT;
  localparam int SR_D    = MAX_LAT + 1;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {CLS_ADD, CLS_MUL, CLS_MISC} opClass_e;

  function automatic opClass_e f_opClass(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100: return CLS_ADD;
      4'b0011:                            return CLS_MUL;
      default:                            return CLS_MISC;
    endcase
  endfunction

  function automatic int f_classLat(input opClass_e c);
    case (c)
      CLS_ADD: return ADD_LAT;
      CLS_MUL: return MUL_LAT;
      default: return MISC_LAT;
    endcase
  endfunction

  logic [WIDTH-1:0] r_memA   [DEPTH];
  logic [WIDTH-1:0] r_memB   [DEPTH];
  logic [3:0]       r_memOp  [DEPTH];
  logic [TAG_W-1:0] r_memTag [DEPTH];
  logic [PTR_W-1:0] r_wrPtr, r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic [SR_D-1:0]  r_srValid;
  logic [TAG_W-1:0] r_srTag [SR_D];

  logic [WIDTH-1:0] r_fpuA, r_fpuB;
  logic [3:0]       r_fpuOp;
  logic             r_wbValid;
  logic [TAG_W-1:0] r_wbTag;
  logic [WIDTH-1:0] r_wbResult;

  logic             w_enq, w_issue, w_laterInFlight;
  logic [3:0]       w_headOp;
  int               w_issueLat;
  logic [SR_D-1:0]  w_srValidNext;
  logic [TAG_W-1:0] w_srTagNext [SR_D];

  assign in_ready   = (r_count < CNT_W'(DEPTH));
  assign w_enq      = in_valid && in_ready;
  assign w_headOp   = r_memOp[r_rdPtr];
  assign w_issueLat = f_classLat(f_opClass(w_headOp));

  // Stage k is captured k edges from now, so anything above stage 0 outlives this edge.
  assign w_laterInFlight = |r_srValid[SR_D-1:1];
  assign w_issue = (r_count != '0) &&
                   ((f_opClass(w_headOp) == f_opClass(r_fpuOp)) || !w_laterInFlight);

  always_comb begin
    w_srValidNext = '0;
    for (int k = 0; k < SR_D; k++) w_srTagNext[k] = '0;
    for (int k = 0; k < SR_D - 1; k++) begin
      w_srValidNext[k] = r_srValid[k+1];
      w_srTagNext[k]   = r_srTag[k+1];
    end
    if (w_issue) begin
      for (int k = 0; k < SR_D; k++) begin
        if (k == w_issueLat) begin
          w_srValidNext[k] = 1'b1;
          w_srTagNext[k]   = r_memTag[r_rdPtr];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_memA[r_wrPtr]   <= in_a;
      r_memB[r_wrPtr]   <= in_b;
      r_memOp[r_wrPtr]  <= in_opcode;
      r_memTag[r_wrPtr] <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_srValid  <= '0;
      r_srTag    <= '{default: '0};
      r_fpuA     <= '0;
      r_fpuB     <= '0;
      r_fpuOp    <= 4'b1111;
      r_wbValid  <= 1'b0;
      r_wbTag    <= '0;
      r_wbResult <= '0;
    end else begin
      if (w_enq) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_issue) begin
        r_rdPtr <= r_rdPtr + 1'b1;
        r_fpuA  <= r_memA[r_rdPtr];
        r_fpuB  <= r_memB[r_rdPtr];
        r_fpuOp <= w_headOp;
      end
      case ({w_enq, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      r_srValid <= w_srValidNext;
      r_srTag   <= w_srTagNext;
      // The opcode still selects this result's pipe here, since a class change waits for this edge.
      r_wbValid <= r_srValid[0];
      if (r_srValid[0]) begin
        r_wbTag    <= r_srTag[0];
        r_wbResult <= fpu_result;
      end
    end
  end

  assign fpu_a      = r_fpuA;
  assign fpu_b      = r_fpuB;
  assign fpu_opcode = r_fpuOp;
  assign wb_valid   = r_wbValid;
  assign wb_tag     = r_wbTag;
  assign wb_result  = r_wbResult;
  assign busy       = (r_count != '0) || (|r_srValid) || r_wbValid;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed and random checks of fpu_issue_seq against a behavioural three-pipe FPU
// and an in-order scoreboard of expected writebacks.
module tb_fpu_issue_seq;

  localparam int WIDTH = 24;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0, in_b = '0;
  logic [3:0]       in_opcode = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [WIDTH-1:0] fpu_a, fpu_b, fpu_result;
  logic [3:0]       fpu_opcode;
  logic             wb_valid, busy;
  logic [TAG_W-1:0] wb_tag;
  logic [WIDTH-1:0] wb_result;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          wbCount [32];
  int unsigned wbCycle [32];

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] res;
  } exp_t;
  exp_t sbQ[$];
  exp_t monE;

  fpu_issue_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .in_tag(in_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_result(fpu_result),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_result(wb_result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] clsOf(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100: return 2'd0;
      4'b0011:                            return 2'd1;
      default:                            return 2'd2;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] addFn(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (op)
      4'b0001: return a - b;
      4'b0010: return b - a;
      4'b0100: return a + b + 24'd1;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] mulFn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = a * b;
    return p[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] miscFn(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return a ^ ~b ^ {op, 20'h0};
  endfunction

  function automatic logic [WIDTH-1:0] expFn(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (clsOf(op))
      2'd0:    return addFn(op, a, b);
      2'd1:    return mulFn(a, b);
      default: return miscFn(op, a, b);
    endcase
  endfunction

  // FPU model: each pipe registers its own computation every cycle; the output mux follows the live opcode.
  logic [WIDTH-1:0] addP0, addP1, mulP0, mulP1, miscP0;
  always @(posedge clk) begin
    addP0  <= addFn(fpu_opcode, fpu_a, fpu_b);
    addP1  <= addP0;
    mulP0  <= mulFn(fpu_a, fpu_b);
    mulP1  <= mulP0;
    miscP0 <= miscFn(fpu_opcode, fpu_a, fpu_b);
  end
  always_comb begin
    case (clsOf(fpu_opcode))
      2'd0:    fpu_result = addP1;
      2'd1:    fpu_result = mulP1;
      default: fpu_result = miscP0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [TAG_W-1:0] tag, output bit accepted);
    exp_t e;
    @(negedge clk);
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    accepted  = in_ready;
    if (accepted) begin
      e.tag = tag;
      e.res = expFn(op, a, b);
      sbQ.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Writeback monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      wbCount[wb_tag]++;
      wbCycle[wb_tag] = cyc;
      if (sbQ.size() == 0) begin
        checkOutput("wb_unexpected", 32'd1, 32'd0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("wb_tag", 32'(wb_tag), 32'(monE.tag));
        checkOutput("wb_result", 32'(wb_result), 32'(monE.res));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          acc;
    int unsigned c0;
    int          accepted;
    int          iter;
    int          curCls;
    logic [3:0]  op;

    // Reset values
    idle(3);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_wb_tag", 32'(wb_tag), 32'd0);
    checkOutput("rst_wb_result", 32'(wb_result), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_fpu_a", 32'(fpu_a), 32'd0);
    checkOutput("rst_fpu_b", 32'(fpu_b), 32'd0);
    checkOutput("rst_fpu_opcode", 32'(fpu_opcode), 32'hF);
    rst = 1'b0;

    // Single ADD op, tag 3
    applyStimulus(4'b0000, 24'h000123, 24'h000456, 5'd3, acc);
    c0 = cyc + 1;
    checkOutput("single_accept", 32'(acc), 32'd1);
    idle(5);
    checkOutput("single_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("single_busy_wb", 32'(busy), 32'd1);
    idle(1);
    checkOutput("single_wb_pulse", 32'(wb_valid), 32'd0);
    checkOutput("single_busy_fall", 32'(busy), 32'd0);
    checkOutput("single_wb_count", 32'(wbCount[3]), 32'd1);
    checkOutput("single_wb_cycle", wbCycle[3], c0 + 4);

    // Same-class stream of four ADD-class opcodes
    applyStimulus(4'b0000, 24'h100001, 24'h000010, 5'd1, acc);
    c0 = cyc + 1;
    applyStimulus(4'b0001, 24'h200002, 24'h000020, 5'd2, acc);
    applyStimulus(4'b0100, 24'h300003, 24'h000030, 5'd3, acc);
    applyStimulus(4'b0010, 24'h400004, 24'h000040, 5'd4, acc);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
    end
    for (int t = 1; t <= 4; t++) begin
      checkOutput("stream_wb_cycle", wbCycle[t], c0 + 3 + t);
    end
    checkOutput("stream_wb_count3", 32'(wbCount[3]), 32'd2);

    // Class change MUL -> MISC waits for the MUL capture edge
    applyStimulus(4'b0011, 24'h000abc, 24'h000def, 5'd7, acc);
    c0 = cyc + 1;
    applyStimulus(4'b1000, 24'h123456, 24'h654321, 5'd8, acc);
    idle(3);
    checkOutput("chg_opcode_hold", 32'(fpu_opcode), 32'h3);
    idle(1);
    checkOutput("chg_opcode_new", 32'(fpu_opcode), 32'h8);
    idle(5);
    checkOutput("chg_wb7_cycle", wbCycle[7], c0 + 4);
    checkOutput("chg_wb8_cycle", wbCycle[8], c0 + 6);
    checkOutput("chg_wb8_count", 32'(wbCount[8]), 32'd1);

    // FIFO full while a class change stalls the head
    applyStimulus(4'b0011, 24'h00f00f, 24'h000777, 5'd10, acc);
    c0 = cyc + 1;
    applyStimulus(4'b0000, 24'h111111, 24'h222222, 5'd11, acc);
    applyStimulus(4'b1000, 24'h333333, 24'h444444, 5'd12, acc);
    applyStimulus(4'b0011, 24'h000555, 24'h000666, 5'd13, acc);
    applyStimulus(4'b0001, 24'h777777, 24'h088888, 5'd14, acc);
    applyStimulus(4'b1001, 24'h999999, 24'haaaaaa, 5'd15, acc);
    checkOutput("full_last_accept", 32'(acc), 32'd1);
    applyStimulus(4'b0000, 24'hbbbbbb, 24'hcccccc, 5'd16, acc);
    checkOutput("full_reject", 32'(acc), 32'd0);
    idle(1);
    checkOutput("full_in_ready_low", 32'(in_ready), 32'd0);
    idle(1);
    checkOutput("full_in_ready_back", 32'(in_ready), 32'd1);
    idle(30);
    for (int t = 10; t <= 15; t++) begin
      checkOutput("full_wb_once", 32'(wbCount[t]), 32'd1);
    end
    checkOutput("full_rejected_absent", 32'(wbCount[16]), 32'd0);
    checkOutput("full_sb_empty", 32'(sbQ.size()), 32'd0);
    checkOutput("full_busy_idle", 32'(busy), 32'd0);

    // Reset in the cycle after the third issue
    applyStimulus(4'b0000, 24'h010101, 24'h020202, 5'd20, acc);
    c0 = cyc + 1;
    applyStimulus(4'b0001, 24'h030303, 24'h040404, 5'd21, acc);
    applyStimulus(4'b0100, 24'h050505, 24'h060606, 5'd22, acc);
    idle(1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    sbQ.delete();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mrst_cycle", cyc, c0 + 4);
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    checkOutput("mrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mrst_fpu_opcode", 32'(fpu_opcode), 32'hF);
    checkOutput("mrst_wb_valid", 32'(wb_valid), 32'd0);
    idle(8);
    for (int t = 20; t <= 22; t++) begin
      checkOutput("mrst_no_wb", 32'(wbCount[t]), 32'd0);
    end

    // Random soak with class runs and random in_valid
    accepted = 0;
    iter = 0;
    curCls = 0;
    while (accepted < 10000 && iter < 70000) begin
      iter++;
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 9) < 3) curCls = int'($urandom_range(0, 2));
        case (curCls)
          0: begin
            case ($urandom_range(0, 3))
              0: op = 4'b0000;
              1: op = 4'b0001;
              2: op = 4'b0010;
              default: op = 4'b0100;
            endcase
          end
          1: op = 4'b0011;
          default: op = 4'($urandom_range(5, 15));
        endcase
        applyStimulus(op, 24'($urandom()), 24'($urandom()), 5'(accepted), acc);
        if (acc) accepted++;
      end else begin
        idle(1);
      end
    end
    checkOutput("soak_budget", 32'(accepted), 32'd10000);
    idle(20);
    checkOutput("soak_sb_empty", 32'(sbQ.size()), 32'd0);
    checkOutput("soak_busy", 32'(busy), 32'd0);
    checkOutput("soak_in_ready", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
